kia_ps2_rx_gen2: RTL and testbench

Second-generation keyboard interface adapter with a parametrised receive-queue depth.
- Deserialises PS/2 device-to-host frames into a FIFO that the CPU reads over a Wishbone-style slave port.
- Adds odd-parity checking, framing-error detection, overrun reporting, a per-frame watchdog for resynchronisation, and an occupancy-count register.
- Sits between the PS/2 connector pins (D_I, C_I) and the CPU bus.

---
 rtl/kia_ps2_rx_gen2.sv | 175 +++++++++++++++++
 tb/tb_kia_ps2_rx_gen2.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/kia_ps2_rx_gen2.sv
// PS/2 device-to-host receiver with parity/framing/overrun checking, a frame
// watchdog, and a parametrised receive FIFO behind a Wishbone-style slave port.
module kia_ps2_rx_gen2 #(
    parameter int unsigned DEPTH_LOG2     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       CLK_I,
    input  logic       RES_I,
    input  logic [1:0] ADR_I,
    input  logic       WE_I,
    input  logic       CYC_I,
    input  logic       STB_I,
    input  logic [7:0] DAT_I,
    output logic       ACK_O,
    output logic [7:0] DAT_O,
    input  logic       D_I,
    input  logic       C_I
);

    localparam int unsigned PW   = DEPTH_LOG2 + 1;
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;

    rx_state_t         state, state_nxt;
    logic              c_s1, c_s2, c_prev, d_s1, d_s2;
    logic              fall;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic              par;
    logic [WD_W-1:0]   wd;
    logic              timeout;
    logic              shift_en, par_en, frame_ok, perr_set, ferr_set;

    logic [7:0]        mem [2**DEPTH_LOG2];
    logic [PW-1:0]     wptr, rptr, count;
    logic              empty, full, push, pop;
    logic              perr, ferr, ovr;
    logic              bus_wr;
    logic [7:0]        clr;

    assign fall    = c_prev & ~c_s2;
    assign timeout = (wd == WD_W'(TIMEOUT_CYCLES));

    always_ff @(posedge CLK_I) begin
        if (RES_I) begin
            c_s1    <= 1'b1;
            c_s2    <= 1'b1;
            c_prev  <= 1'b1;
            d_s1    <= 1'b1;
            d_s2    <= 1'b1;
            state   <= S_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            wd      <= '0;
        end else begin
            c_s1   <= C_I;
            c_s2   <= c_s1;
            c_prev <= c_s2;
            d_s1   <= D_I;
            d_s2   <= d_s1;
            state  <= state_nxt;
            // Clearing on timeout as well keeps the counter from wrapping past the limit
            if (state == S_IDLE || fall || timeout)
                wd <= '0;
            else
                wd <= wd + 1'b1;
            if (state == S_IDLE)
                bit_cnt <= '0;
            else if (shift_en)
                bit_cnt <= bit_cnt + 1'b1;
            if (shift_en)
                shreg <= {d_s2, shreg[7:1]};
            if (par_en)
                par <= d_s2;
        end
    end

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        frame_ok  = 1'b0;
        perr_set  = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall && !d_s2)
                    state_nxt = S_DATA;
            end
            S_DATA: begin
                if (fall) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7)
                        state_nxt = S_PARITY;
                end else if (timeout) begin
                    ferr_set  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_PARITY: begin
                if (fall) begin
                    par_en    = 1'b1;
                    state_nxt = S_STOP;
                end else if (timeout) begin
                    ferr_set  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_STOP: begin
                if (fall) begin
                    state_nxt = S_IDLE;
                    if (!d_s2)
                        ferr_set = 1'b1;
                    else if (^{shreg, par})
                        frame_ok = 1'b1;
                    else
                        perr_set = 1'b1;
                end else if (timeout) begin
                    ferr_set  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign count  = wptr - rptr;
    assign empty  = (wptr == rptr);
    assign full   = (wptr[PW-1] != rptr[PW-1]) &&
                    (wptr[PW-2:0] == rptr[PW-2:0]);
    assign bus_wr = ACK_O & WE_I;
    assign pop    = bus_wr && (ADR_I == 2'd1) && !empty;
    assign push   = frame_ok & ~full;
    assign clr    = (bus_wr && (ADR_I == 2'd3)) ? DAT_I : 8'h00;

    always_ff @(posedge CLK_I) begin
        if (RES_I) begin
            ACK_O <= 1'b0;
            wptr  <= '0;
            rptr  <= '0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            ACK_O <= CYC_I & STB_I & ~ACK_O;
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            perr <= (perr & ~clr[4]) | perr_set;
            ferr <= (ferr & ~clr[3]) | ferr_set;
            ovr  <= (ovr  & ~clr[2]) | (frame_ok & full);
        end
    end

    always_ff @(posedge CLK_I) begin
        if (push)
            mem[wptr[PW-2:0]] <= shreg;
    end

    always_comb begin
        DAT_O = '0;
        if (ACK_O && !WE_I) begin
            case (ADR_I)
                2'd0:    DAT_O = {3'b000, ovr, ferr, perr, full, empty};
                2'd1:    DAT_O = empty ? 8'h00 : mem[rptr[PW-2:0]];
                2'd2:    DAT_O = 8'(count);
                default: DAT_O = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_kia_ps2_rx_gen2.sv
// Self-checking bench for kia_ps2_rx_gen2: directed test-plan steps followed by
// randomized frames/bus traffic checked against a queue-and-flags model.
module tb_kia_ps2_rx_gen2;

    localparam int unsigned DL2   = 4;
    localparam int unsigned DEPTH = 2**DL2;
    localparam int unsigned TMO   = 100;

    logic       clk = 1'b0;
    logic       RES_I, WE_I, CYC_I, STB_I, D_I, C_I;
    logic [1:0] ADR_I;
    logic [7:0] DAT_I;
    logic       ACK_O;
    logic [7:0] DAT_O;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] q[$];
    bit         m_ovr, m_ferr, m_perr;

    always #5 clk = ~clk;

    kia_ps2_rx_gen2 #(.DEPTH_LOG2(DL2), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK_I(clk), .RES_I(RES_I), .ADR_I(ADR_I), .WE_I(WE_I),
        .CYC_I(CYC_I), .STB_I(STB_I), .DAT_I(DAT_I), .ACK_O(ACK_O),
        .DAT_O(DAT_O), .D_I(D_I), .C_I(C_I)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk); D_I = b;
        repeat (4) @(negedge clk);
        C_I = 1'b0;
        repeat (4) @(negedge clk);
        C_I = 1'b1;
    endtask

    // kind: 0 good, 1 wrong parity, 2 stop bit low
    task automatic send_frame(input logic [7:0] d, input int kind);
        logic p;
        p = ~^d;
        if (kind == 1) p = ~p;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(p);
        ps2_bit(kind == 2 ? 1'b0 : 1'b1);
        D_I = 1'b1;
        repeat (6) @(negedge clk);
        if (kind == 1)      m_perr = 1'b1;
        else if (kind == 2) m_ferr = 1'b1;
        else if (q.size() < DEPTH) q.push_back(d);
        else                m_ovr = 1'b1;
    endtask

    task automatic bus(input logic [1:0] a, input logic w, input logic [7:0] wd,
                       output logic [7:0] rd);
        @(negedge clk);
        ADR_I = a; WE_I = w; DAT_I = wd; CYC_I = 1'b1; STB_I = 1'b1;
        @(negedge clk);
        chk("ack", {7'b0, ACK_O}, 8'h01);
        rd = DAT_O;
        CYC_I = 1'b0; STB_I = 1'b0;
        @(negedge clk);
        WE_I = 1'b0; ADR_I = 2'd0; DAT_I = 8'h00;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [7:0] v);
        bus(a, 1'b0, 8'h00, v);
    endtask

    task automatic pop_one();
        logic [7:0] dummy;
        bus(2'd1, 1'b1, 8'hA5, dummy);
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic errclr(input logic [7:0] v);
        logic [7:0] dummy;
        bus(2'd3, 1'b1, v, dummy);
        if (v[2]) m_ovr  = 1'b0;
        if (v[3]) m_ferr = 1'b0;
        if (v[4]) m_perr = 1'b0;
    endtask

    function automatic logic [7:0] exp_stat();
        return {3'b000, m_ovr, m_ferr, m_perr, q.size() == DEPTH, q.size() == 0};
    endfunction

    task automatic check_all(input string tag);
        logic [7:0] v;
        rd_reg(2'd0, v); chk({tag, "_stat"},  v, exp_stat());
        rd_reg(2'd2, v); chk({tag, "_count"}, v, 8'(q.size()));
        rd_reg(2'd1, v); chk({tag, "_data"},  v, (q.size() > 0) ? q[0] : 8'h00);
    endtask

    initial begin
        logic [7:0] v;
        int unsigned op;
        RES_I = 1'b1; WE_I = 1'b0; CYC_I = 1'b0; STB_I = 1'b0;
        ADR_I = 2'd0; DAT_I = 8'h00; D_I = 1'b1; C_I = 1'b1;
        m_ovr = 0; m_ferr = 0; m_perr = 0;
        repeat (3) @(negedge clk);
        chk("rst_ack",  {7'b0, ACK_O}, 8'h00);
        chk("rst_dato", DAT_O, 8'h00);
        RES_I = 1'b0;
        check_all("reset");

        // 1: single good frame
        send_frame(8'h1C, 0);
        rd_reg(2'd0, v); chk("t1_stat",  v, 8'h00);
        rd_reg(2'd2, v); chk("t1_count", v, 8'h01);
        rd_reg(2'd1, v); chk("t1_data",  v, 8'h1C);
        pop_one();
        rd_reg(2'd0, v); chk("t1_stat_after", v, 8'h01);
        rd_reg(2'd2, v); chk("t1_count_after", v, 8'h00);

        // 2: overflow by one frame
        for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 0);
        rd_reg(2'd0, v); chk("t2_stat_full",  v, 8'h12);
        rd_reg(2'd2, v); chk("t2_count_full", v, 8'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            rd_reg(2'd1, v); chk("t2_pop_data", v, 8'(i));
            pop_one();
        end
        rd_reg(2'd0, v); chk("t2_stat_drained", v, 8'h11);
        errclr(8'h04);
        rd_reg(2'd0, v); chk("t2_stat_clr", v, 8'h01);

        // 3: parity error
        send_frame(8'h5A, 1);
        rd_reg(2'd2, v); chk("t3_count", v, 8'h00);
        rd_reg(2'd0, v); chk("t3_stat",  v, 8'h05);
        errclr(8'h10);
        rd_reg(2'd0, v); chk("t3_stat_clr", v, 8'h01);

        // 4: framing error then recovery
        send_frame(8'h33, 2);
        rd_reg(2'd0, v); chk("t4_stat", v, 8'h09);
        send_frame(8'h44, 0);
        check_all("t4_next");
        pop_one();
        errclr(8'h08);

        // 5: watchdog abort mid-frame
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
        D_I = 1'b1;
        repeat (TMO + 5) @(negedge clk);
        m_ferr = 1'b1;
        rd_reg(2'd0, v); chk("t5_stat",  v, 8'h09);
        rd_reg(2'd2, v); chk("t5_count", v, 8'h00);
        send_frame(8'h29, 0);
        check_all("t5_next");
        pop_one();
        errclr(8'h1C);

        // 6a: held request pops every second cycle
        send_frame(8'h61, 0); send_frame(8'h62, 0); send_frame(8'h63, 0);
        @(negedge clk);
        ADR_I = 2'd1; WE_I = 1'b1; CYC_I = 1'b1; STB_I = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6_held_ack", {7'b0, ACK_O}, (k % 2 == 0) ? 8'h01 : 8'h00);
        end
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; ADR_I = 2'd0;
        void'(q.pop_front()); void'(q.pop_front());
        check_all("t6_held");

        // 6b: reset mid-frame with bytes queued
        send_frame(8'h64, 0); send_frame(8'h65, 0);
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
        @(negedge clk); RES_I = 1'b1; CYC_I = 1'b1; STB_I = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_rst_ack", {7'b0, ACK_O}, 8'h00);
        RES_I = 1'b0; CYC_I = 1'b0; STB_I = 1'b0;
        q.delete(); m_ovr = 0; m_ferr = 0; m_perr = 0;
        repeat (2) @(negedge clk);
        rd_reg(2'd0, v); chk("t6_rst_stat",  v, 8'h01);
        rd_reg(2'd2, v); chk("t6_rst_count", v, 8'h00);
        send_frame(8'h77, 0);
        check_all("t6_after_rst");

        // randomized traffic against the model
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 5) begin
                op = $urandom_range(0, 7);
                send_frame(8'($urandom), (op == 0) ? 1 : (op == 1) ? 2 : 0);
            end else if (op <= 7) begin
                pop_one();
            end else if (op == 8) begin
                errclr(8'($urandom));
            end
            check_all("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
